// File: rtl/cv32e40s_pkg.sv
// cv32e40s_pkg
// Shared types for the memory protection unit and its PMA checker.
//   pma_cfg_t     : one PMA region (inclusive byte address range plus attributes)
//   PMA_R_DEFAULT : all-zero region, non-main, no attributes
//   mpu_state_e   : MPU fake-response FSM states
//   pma_region_match() : address-in-region test used by the PMA checker
package cv32e40s_pkg;

  typedef struct packed {
    logic [31:0] addr_low;
    logic [31:0] addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
  } pma_cfg_t;

  localparam pma_cfg_t PMA_R_DEFAULT = '{
    addr_low:   32'h0000_0000,
    addr_high:  32'h0000_0000,
    main:       1'b0,
    bufferable: 1'b0,
    cacheable:  1'b0
  };

  typedef enum logic [1:0] {
    MPU_IDLE     = 2'd0,
    MPU_ERR_WAIT = 2'd1,
    MPU_ERR_RESP = 2'd2
  } mpu_state_e;

  // Both bounds are inclusive, so a region can reach the top of memory.
  function automatic logic pma_region_match(input pma_cfg_t cfg, input logic [31:0] addr);
    return (addr >= cfg.addr_low) && (addr <= cfg.addr_high);
  endfunction

endpackage

// File: rtl/cv32e40s_pma.sv
// cv32e40s_pma
// Combinational physical memory attribute checker.
//   trans_addr_i          : byte address of the access
//   instr_fetch_access_i  : access is an instruction fetch
//   load_access_i         : access is a data load
//   misaligned_access_i   : access is one half of a split misaligned access
//   pma_err_o             : access is not allowed by the PMA
//   pma_bufferable_o      : store may be buffered
//   pma_cacheable_o       : access may be cached
module cv32e40s_pma import cv32e40s_pkg::*; #(
  parameter int       PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default:PMA_R_DEFAULT}
) (
  input  logic [31:0] trans_addr_i,
  input  logic        instr_fetch_access_i,
  input  logic        load_access_i,
  input  logic        misaligned_access_i,
  output logic        pma_err_o,
  output logic        pma_bufferable_o,
  output logic        pma_cacheable_o
);

  logic region_main;
  logic region_bufferable;
  logic region_cacheable;

  // With no regions configured the whole address space is plain main memory.
  // Otherwise an unmatched address is I/O, and the lowest-indexed matching
  // region wins (the loop runs downwards so lower indices overwrite).
  always_comb begin
    region_main       = 1'b0;
    region_bufferable = 1'b0;
    region_cacheable  = 1'b0;
    if (PMA_NUM_REGIONS == 0) begin
      region_main = 1'b1;
    end else begin
      for (int i = PMA_NUM_REGIONS - 1; i >= 0; i--) begin
        if (pma_region_match(PMA_CFG[i], trans_addr_i)) begin
          region_main       = PMA_CFG[i].main;
          region_bufferable = PMA_CFG[i].bufferable;
          region_cacheable  = PMA_CFG[i].cacheable;
        end
      end
    end
  end

  // Code may only be fetched from main memory, and I/O cannot tolerate the
  // split accesses a misaligned transfer produces.
  assign pma_err_o        = !region_main && (instr_fetch_access_i || misaligned_access_i);
  // Buffering only makes sense for stores.
  assign pma_bufferable_o = region_bufferable && !instr_fetch_access_i && !load_access_i;
  assign pma_cacheable_o  = region_cacheable;

endmodule

// File: rtl/cv32e40s_mpu.sv
// cv32e40s_mpu
// Memory protection unit between a core transaction source (fetch or LSU)
// and its OBI bus interface. Permitted requests are forwarded with PMA
// attributes; blocked requests are swallowed and answered with a locally
// generated error response once all earlier bus transactions have returned.
//   core_trans_*   : request from the core (valid/ready, addr, we, misaligned)
//   bus_trans_*    : request to the bus (valid/ready, addr, we, bufferable, cacheable)
//   bus_resp_*     : response from the bus (valid, rdata, err)
//   core_resp_*    : response to the core (valid, rdata, err, mpu_err)
module cv32e40s_mpu import cv32e40s_pkg::*; #(
  parameter int       IF_STAGE        = 1,
  parameter int       PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t PMA_CFG[PMA_NUM_REGIONS-1:0] = '{default:PMA_R_DEFAULT},
  parameter int       MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        core_trans_valid_i,
  output logic        core_trans_ready_o,
  input  logic [31:0] core_trans_addr_i,
  input  logic        core_trans_we_i,
  input  logic        core_trans_misaligned_i,

  output logic        bus_trans_valid_o,
  input  logic        bus_trans_ready_i,
  output logic [31:0] bus_trans_addr_o,
  output logic        bus_trans_we_o,
  output logic        bus_trans_bufferable_o,
  output logic        bus_trans_cacheable_o,

  input  logic        bus_resp_valid_i,
  input  logic [31:0] bus_resp_rdata_i,
  input  logic        bus_resp_err_i,

  output logic        core_resp_valid_o,
  output logic [31:0] core_resp_rdata_o,
  output logic        core_resp_err_o,
  output logic        core_resp_mpu_err_o
);

  localparam int               CNT_W   = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
  localparam logic             IS_FETCH = (IF_STAGE != 0);

  mpu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic pma_err;
  logic pma_bufferable;
  logic pma_cacheable;
  logic load_access;
  logic cnt_full;
  logic bus_accept;
  logic all_resp_done;

  assign load_access = !IS_FETCH && !core_trans_we_i;

  cv32e40s_pma #(
    .PMA_NUM_REGIONS (PMA_NUM_REGIONS),
    .PMA_CFG         (PMA_CFG)
  ) pma_i (
    .trans_addr_i         (core_trans_addr_i),
    .instr_fetch_access_i (IS_FETCH),
    .load_access_i        (load_access),
    .misaligned_access_i  (core_trans_misaligned_i),
    .pma_err_o            (pma_err),
    .pma_bufferable_o     (pma_bufferable),
    .pma_cacheable_o      (pma_cacheable)
  );

  assign bus_trans_addr_o       = core_trans_addr_i;
  assign bus_trans_we_o         = core_trans_we_i;
  assign bus_trans_bufferable_o = pma_bufferable;
  assign bus_trans_cacheable_o  = pma_cacheable;

  assign cnt_full   = (cnt_q == CNT_MAX);
  assign bus_accept = bus_trans_valid_o && bus_trans_ready_i;

  // True when no bus transaction will be outstanding after this cycle.
  // Only used in states where no new bus request can be accepted, so the
  // accept term does not need to be considered (and no comb loop forms).
  assign all_resp_done = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && bus_resp_valid_i);

  // Outstanding counter; the guards keep it from wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (bus_accept && !bus_resp_valid_i && !cnt_full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!bus_accept && bus_resp_valid_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d             = state_q;
    core_trans_ready_o  = 1'b0;
    bus_trans_valid_o   = 1'b0;
    core_resp_valid_o   = bus_resp_valid_i;
    core_resp_rdata_o   = bus_resp_rdata_i;
    core_resp_err_o     = bus_resp_err_i;
    core_resp_mpu_err_o = 1'b0;

    case (state_q)
      MPU_IDLE: begin
        bus_trans_valid_o  = core_trans_valid_i && !pma_err && !cnt_full;
        // Blocked requests are taken immediately, even with the counter full.
        core_trans_ready_o = pma_err ? 1'b1 : (bus_trans_ready_i && !cnt_full);
        if (core_trans_valid_i && pma_err) begin
          state_d = all_resp_done ? MPU_ERR_RESP : MPU_ERR_WAIT;
        end
      end
      MPU_ERR_WAIT: begin
        if (all_resp_done) begin
          state_d = MPU_ERR_RESP;
        end
      end
      MPU_ERR_RESP: begin
        core_resp_valid_o   = 1'b1;
        core_resp_rdata_o   = 32'h0;
        core_resp_err_o     = 1'b0;
        core_resp_mpu_err_o = 1'b1;
        state_d             = MPU_IDLE;
      end
      default: begin
        state_d = MPU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MPU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cv32e40s_mpu.sv
// tb_cv32e40s_mpu
// Two MPU instances share a clock and reset: index 0 is the fetch side
// (IF_STAGE=1), index 1 the LSU side (IF_STAGE=0). Both use the same
// three-band memory map: 0x0xxx_xxxx main+cacheable, 0x1xxx_xxxx
// main+bufferable, everything above is I/O. A transaction-level model
// predicts every output each cycle; directed steps add literal checks.
module tb_cv32e40s_mpu;
  import cv32e40s_pkg::*;

  localparam int MAX_OUT = 2;

  localparam pma_cfg_t R0 = '{addr_low: 32'h0000_0000, addr_high: 32'h0FFF_FFFF,
                              main: 1'b1, bufferable: 1'b0, cacheable: 1'b1};
  localparam pma_cfg_t R1 = '{addr_low: 32'h1000_0000, addr_high: 32'h1FFF_FFFF,
                              main: 1'b1, bufferable: 1'b1, cacheable: 1'b0};
  // Leftmost element lands on index 1.
  localparam pma_cfg_t TB_PMA_CFG [1:0] = '{R1, R0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        core_valid [2];
  logic        core_ready [2];
  logic [31:0] core_addr  [2];
  logic        core_we    [2];
  logic        core_mis   [2];
  logic        bus_valid  [2];
  logic        bus_ready  [2];
  logic [31:0] bus_addr   [2];
  logic        bus_we     [2];
  logic        bus_buf    [2];
  logic        bus_cach   [2];
  logic        bus_rvalid [2];
  logic [31:0] bus_rdata  [2];
  logic        bus_rerr   [2];
  logic        resp_valid [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        resp_mpu   [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: outstanding bus transactions, a blocked request waiting
  // for them to drain, and a fake error response due this cycle.
  int m_out  [2] = '{0, 0};
  bit m_wait [2] = '{0, 0};
  bit m_fake [2] = '{0, 0};
  int nx_out  [2] = '{0, 0};
  bit nx_wait [2] = '{0, 0};
  bit nx_fake [2] = '{0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cv32e40s_mpu #(
      .IF_STAGE        ((g == 0) ? 1 : 0),
      .PMA_NUM_REGIONS (2),
      .PMA_CFG         (TB_PMA_CFG),
      .MAX_OUTSTANDING (MAX_OUT)
    ) u_dut (
      .clk                     (clk),
      .rst_n                   (rst_n),
      .core_trans_valid_i      (core_valid[g]),
      .core_trans_ready_o      (core_ready[g]),
      .core_trans_addr_i       (core_addr[g]),
      .core_trans_we_i         (core_we[g]),
      .core_trans_misaligned_i (core_mis[g]),
      .bus_trans_valid_o       (bus_valid[g]),
      .bus_trans_ready_i       (bus_ready[g]),
      .bus_trans_addr_o        (bus_addr[g]),
      .bus_trans_we_o          (bus_we[g]),
      .bus_trans_bufferable_o  (bus_buf[g]),
      .bus_trans_cacheable_o   (bus_cach[g]),
      .bus_resp_valid_i        (bus_rvalid[g]),
      .bus_resp_rdata_i        (bus_rdata[g]),
      .bus_resp_err_i          (bus_rerr[g]),
      .core_resp_valid_o       (resp_valid[g]),
      .core_resp_rdata_o       (resp_rdata[g]),
      .core_resp_err_o         (resp_err[g]),
      .core_resp_mpu_err_o     (resp_mpu[g])
    );
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory map as a plain address-band lookup, then the access rules.
  function automatic void model_pma(input int k, input logic [31:0] a, input logic we,
                                    input logic mis, output bit err, output bit bf, output bit ca);
    bit fetch = (k == 0);
    bit main_r, buf_r, cach_r;
    if (a <= 32'h0FFF_FFFF) begin
      main_r = 1; buf_r = 0; cach_r = 1;
    end else if (a <= 32'h1FFF_FFFF) begin
      main_r = 1; buf_r = 1; cach_r = 0;
    end else begin
      main_r = 0; buf_r = 0; cach_r = 0;
    end
    err = !main_r && (fetch || mis);
    bf  = buf_r && !fetch && we;
    ca  = cach_r;
  endfunction

  // Per-cycle prediction and comparison, away from the rising edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      bit err, bf, ca, e_ready, e_bvalid, e_rvalid, e_rerr, e_mpu, blk;
      logic [31:0] e_rdata;
      int o;
      model_pma(k, core_addr[k], core_we[k], core_mis[k], err, bf, ca);
      e_rvalid = bus_rvalid[k];
      e_rdata  = bus_rdata[k];
      e_rerr   = bus_rerr[k];
      e_mpu    = 0;
      e_ready  = 0;
      e_bvalid = 0;
      blk      = 0;
      if (m_fake[k]) begin
        e_rvalid = 1; e_rdata = 32'h0; e_rerr = 0; e_mpu = 1;
      end else if (!m_wait[k]) begin
        e_bvalid = core_valid[k] && !err && (m_out[k] < MAX_OUT);
        e_ready  = err || (bus_ready[k] && (m_out[k] < MAX_OUT));
        blk      = core_valid[k] && err;
      end
      if (bus_rvalid[k]) check_output($sformatf("i%0d_resp_legal", k), 32'(m_out[k] > 0), 32'd1);
      check_output($sformatf("i%0d_core_ready", k), 32'(core_ready[k]), 32'(e_ready));
      check_output($sformatf("i%0d_bus_valid", k), 32'(bus_valid[k]), 32'(e_bvalid));
      if (e_bvalid) begin
        check_output($sformatf("i%0d_bus_addr", k), bus_addr[k], core_addr[k]);
        check_output($sformatf("i%0d_bus_we", k), 32'(bus_we[k]), 32'(core_we[k]));
        check_output($sformatf("i%0d_bus_buf", k), 32'(bus_buf[k]), 32'(bf));
        check_output($sformatf("i%0d_bus_cach", k), 32'(bus_cach[k]), 32'(ca));
      end
      check_output($sformatf("i%0d_resp_valid", k), 32'(resp_valid[k]), 32'(e_rvalid));
      if (e_rvalid) begin
        check_output($sformatf("i%0d_resp_rdata", k), resp_rdata[k], e_rdata);
        check_output($sformatf("i%0d_resp_err", k), 32'(resp_err[k]), 32'(e_rerr));
        check_output($sformatf("i%0d_resp_mpu", k), 32'(resp_mpu[k]), 32'(e_mpu));
      end
      o = m_out[k] + int'(e_bvalid && bus_ready[k]) - int'(bus_rvalid[k]);
      if (o < 0) o = 0;
      nx_out[k]  = o;
      nx_fake[k] = (blk || m_wait[k]) && (o == 0);
      nx_wait[k] = (blk || m_wait[k]) && (o != 0);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_out[k] <= 0; m_wait[k] <= 0; m_fake[k] <= 0;
      end else begin
        m_out[k] <= nx_out[k]; m_wait[k] <= nx_wait[k]; m_fake[k] <= nx_fake[k];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input int k, input bit v, input logic [31:0] a, input bit we,
                                input bit mis, input bit brdy);
    core_valid[k] = v;
    core_addr[k]  = a;
    core_we[k]    = we;
    core_mis[k]   = mis;
    bus_ready[k]  = brdy;
  endtask

  task automatic apply_resp(input int k, input bit v, input logic [31:0] d);
    bus_rvalid[k] = v;
    bus_rdata[k]  = d;
    bus_rerr[k]   = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(k, 0, 32'h0, 0, 0, 0);
      apply_resp(k, 0, 32'h0);
    end

    // Reset state
    sample();
    check_output("rst_resp_valid0", 32'(resp_valid[0]), 32'd0);
    check_output("rst_bus_valid0", 32'(bus_valid[0]), 32'd0);
    check_output("rst_ready1", 32'(core_ready[1]), 32'd0);
    check_output("rst_resp_valid1", 32'(resp_valid[1]), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Permitted fetch and its response
    apply_stimulus(0, 1, 32'h0000_0100, 0, 0, 1);
    sample();
    check_output("fetch_bus_valid", 32'(bus_valid[0]), 32'd1);
    check_output("fetch_ready", 32'(core_ready[0]), 32'd1);
    check_output("fetch_cacheable", 32'(bus_cach[0]), 32'd1);
    next_cycle();
    apply_stimulus(0, 0, 32'h0, 0, 0, 0);
    next_cycle();
    apply_resp(0, 1, 32'hDEAD_BEEF);
    sample();
    check_output("fetch_rdata", resp_rdata[0], 32'hDEAD_BEEF);
    check_output("fetch_mpu_err", 32'(resp_mpu[0]), 32'd0);
    next_cycle();
    apply_resp(0, 0, 32'h0);

    // Blocked fetch with nothing outstanding
    apply_stimulus(0, 1, 32'h2000_0000, 0, 0, 0);
    sample();
    check_output("blk_fetch_ready", 32'(core_ready[0]), 32'd1);
    check_output("blk_fetch_bus_valid", 32'(bus_valid[0]), 32'd0);
    check_output("blk_fetch_no_resp", 32'(resp_valid[0]), 32'd0);
    next_cycle();
    apply_stimulus(0, 0, 32'h0, 0, 0, 0);
    sample();
    check_output("blk_fetch_resp", 32'(resp_valid[0]), 32'd1);
    check_output("blk_fetch_mpu", 32'(resp_mpu[0]), 32'd1);
    check_output("blk_fetch_rdata", resp_rdata[0], 32'h0);
    next_cycle();
    sample();
    check_output("blk_fetch_one_cycle", 32'(resp_valid[0]), 32'd0);
    next_cycle();

    // Two loads outstanding, then a blocked misaligned store to I/O
    apply_stimulus(1, 1, 32'h0000_0100, 0, 0, 1);
    next_cycle();
    apply_stimulus(1, 1, 32'h0000_0104, 0, 0, 1);
    next_cycle();
    apply_stimulus(1, 1, 32'h2000_0000, 1, 1, 1);
    sample();
    check_output("blk_st_ready", 32'(core_ready[1]), 32'd1);
    check_output("blk_st_bus_valid", 32'(bus_valid[1]), 32'd0);
    next_cycle();
    apply_stimulus(1, 1, 32'h0000_0108, 0, 0, 1);
    apply_resp(1, 1, 32'h1111_1111);
    sample();
    check_output("wait_rsp1_rdata", resp_rdata[1], 32'h1111_1111);
    check_output("wait_rsp1_mpu", 32'(resp_mpu[1]), 32'd0);
    next_cycle();
    apply_resp(1, 1, 32'h2222_2222);
    sample();
    check_output("wait_ready_low", 32'(core_ready[1]), 32'd0);
    check_output("wait_rsp2_rdata", resp_rdata[1], 32'h2222_2222);
    next_cycle();
    apply_stimulus(1, 0, 32'h0, 0, 0, 0);
    apply_resp(1, 0, 32'h0);
    sample();
    check_output("wait_fake_valid", 32'(resp_valid[1]), 32'd1);
    check_output("wait_fake_mpu", 32'(resp_mpu[1]), 32'd1);
    next_cycle();
    next_cycle();

    // Bufferable region: store is bufferable, load is not; aligned I/O store passes
    apply_stimulus(1, 1, 32'h1000_0000, 1, 0, 1);
    sample();
    check_output("st_buf", 32'(bus_buf[1]), 32'd1);
    check_output("st_cach", 32'(bus_cach[1]), 32'd0);
    next_cycle();
    apply_stimulus(1, 1, 32'h1000_0004, 0, 0, 1);
    sample();
    check_output("ld_buf", 32'(bus_buf[1]), 32'd0);
    next_cycle();
    apply_stimulus(1, 0, 32'h0, 0, 0, 0);
    apply_resp(1, 1, 32'h3333_3333);
    next_cycle();
    apply_stimulus(1, 1, 32'h3000_0000, 1, 0, 1);
    apply_resp(1, 1, 32'h4444_4444);
    sample();
    check_output("io_st_pass", 32'(bus_valid[1]), 32'd1);
    next_cycle();
    apply_stimulus(1, 0, 32'h0, 0, 0, 0);
    apply_resp(1, 1, 32'h5555_5555);
    next_cycle();
    apply_resp(1, 0, 32'h0);
    next_cycle();

    // Outstanding limit stalls the third request, even alongside a response
    apply_stimulus(1, 1, 32'h0000_0200, 0, 0, 1);
    next_cycle();
    apply_stimulus(1, 1, 32'h0000_0204, 0, 0, 1);
    next_cycle();
    apply_stimulus(1, 1, 32'h0000_0208, 0, 0, 1);
    sample();
    check_output("full_ready", 32'(core_ready[1]), 32'd0);
    check_output("full_bus_valid", 32'(bus_valid[1]), 32'd0);
    next_cycle();
    apply_resp(1, 1, 32'h6666_6666);
    sample();
    check_output("full_resp_same_cycle", 32'(core_ready[1]), 32'd0);
    next_cycle();
    apply_resp(1, 0, 32'h0);
    sample();
    check_output("released_ready", 32'(core_ready[1]), 32'd1);
    check_output("released_bus_valid", 32'(bus_valid[1]), 32'd1);
    next_cycle();
    apply_stimulus(1, 0, 32'h0, 0, 0, 0);
    apply_resp(1, 1, 32'h7777_7777);
    next_cycle();
    apply_resp(1, 1, 32'h8888_8888);
    next_cycle();
    apply_resp(1, 0, 32'h0);
    next_cycle();

    // Reset while waiting to deliver a fake error
    apply_stimulus(1, 1, 32'h0000_0300, 0, 0, 1);
    next_cycle();
    apply_stimulus(1, 1, 32'h2000_0000, 0, 1, 0);
    next_cycle();
    apply_stimulus(1, 0, 32'h0, 0, 0, 0);
    sample();
    check_output("pre_rst_wait_ready", 32'(core_ready[1]), 32'd0);
    next_cycle();
    rst_n = 1'b0;
    sample();
    check_output("mid_rst_resp", 32'(resp_valid[1]), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_output("post_rst_no_fake", 32'(resp_valid[1]), 32'd0);
      next_cycle();
    end
    // Counter must have cleared: a blocked access now answers after one cycle
    apply_stimulus(1, 1, 32'h2000_0004, 1, 1, 0);
    next_cycle();
    apply_stimulus(1, 0, 32'h0, 0, 0, 0);
    sample();
    check_output("post_rst_fake", 32'(resp_mpu[1]), 32'd1);
    next_cycle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cv32e40s_mpu.md
# cv32e40s_mpu

Memory protection unit between a core-side transaction source (instruction fetch or LSU) and its OBI bus interface. Each request is classified with the PMA checker. Permitted requests pass to the bus with bufferable/cacheable attributes. Blocked requests are consumed without reaching the bus, and the core receives a locally generated error response after all earlier bus transactions have completed, so response order is preserved.

## Interface
- IF_STAGE, default 1: 1 = instruction-fetch side (every access is a fetch), 0 = LSU side.
- PMA_NUM_REGIONS, default 0: number of PMA regions, passed to the checker.
- PMA_CFG, default '{default:PMA_R_DEFAULT}: region table, passed to the checker.
- MAX_OUTSTANDING, default 2: maximum accepted-but-unanswered bus transactions (≥1).
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- core_trans_valid_i  in  1  core request valid.
- core_trans_ready_o  out  1  core request accepted.
- core_trans_addr_i  in  32  byte address.
- core_trans_we_i  in  1  write (ignored when IF_STAGE=1).
- core_trans_misaligned_i  in  1  request is part of a split misaligned access.
- bus_trans_valid_o  out  1  bus request valid.
- bus_trans_ready_i  in  1  bus request accepted.
- bus_trans_addr_o  out  32  equals core_trans_addr_i.
- bus_trans_we_o  out  1  equals core_trans_we_i.
- bus_trans_bufferable_o  out  1  PMA bufferable result.
- bus_trans_cacheable_o  out  1  PMA cacheable result.
- bus_resp_valid_i  in  1  bus response valid.
- bus_resp_rdata_i  in  32  response data.
- bus_resp_err_i  in  1  bus error.
- core_resp_valid_o  out  1  response to core.
- core_resp_rdata_o  out  32  response data.
- core_resp_err_o  out  1  bus error.
- core_resp_mpu_err_o  out  1  MPU-blocked response.

## Operation
- PMA checker inputs:
  - instr_fetch = IF_STAGE.
  - load = !IF_STAGE && !core_trans_we_i.
  - misaligned = core_trans_misaligned_i.
- pma_err is combinational from the current request.
- Outstanding counter `cnt`, width $clog2(MAX_OUTSTANDING+1):
  - +1 on bus accept (bus_trans_valid_o && bus_trans_ready_i).
  - −1 on bus_resp_valid_i.
  - Both in the same cycle: unchanged.
  - Never wraps.
  - bus_resp_valid_i while cnt==0 is illegal (bench assertion).
- States (mpu_state_e): MPU_IDLE, MPU_ERR_WAIT, MPU_ERR_RESP.
- In MPU_IDLE:
  - bus_trans_valid_o = core_trans_valid_i && !pma_err && cnt<MAX_OUTSTANDING.
  - core_trans_ready_o = pma_err ? 1 : (bus_trans_ready_i && cnt<MAX_OUTSTANDING).
- Blocked request (valid && pma_err in MPU_IDLE):
  - The request is accepted and never forwarded.
  - Next state is MPU_ERR_RESP if cnt==0 (or cnt==1 with bus_resp_valid_i this cycle); otherwise MPU_ERR_WAIT.
- MPU_ERR_WAIT:
  - core_trans_ready_o=0 and bus_trans_valid_o=0.
  - Bus responses keep passing through.
  - Moves to MPU_ERR_RESP in the cycle after cnt reaches 0.
- MPU_ERR_RESP:
  - Drives core_resp_valid_o=1, core_resp_mpu_err_o=1, core_resp_err_o=0, core_resp_rdata_o=0 for exactly one cycle.
  - core_trans_ready_o=0.
  - Next state is MPU_IDLE.
- Pass-through responses (state other than MPU_ERR_RESP):
  - core_resp_valid_o = bus_resp_valid_i, core_resp_rdata_o = bus_resp_rdata_i, core_resp_err_o = bus_resp_err_i, core_resp_mpu_err_o = 0.

## Timing
- Reset: state MPU_IDLE, cnt=0.
  - Registered outputs are 0.
  - Combinational outputs depend only on inputs and reset state.
- Reset mid-operation: any pending fake response is dropped and cnt clears; in-flight bus responses after reset are the system's responsibility.
- Request path is zero latency (combinational valid/ready).
- Fake error latency after the blocked accept: 1 cycle with no outstanding transactions; otherwise 1 cycle after the last outstanding response.
- At most one blocked request is in progress at a time; the core is back-pressured until the fake response completes.
- cnt==MAX_OUTSTANDING stalls new permitted requests, even if a response arrives in the same cycle.
- A blocked request is accepted even when cnt==MAX_OUTSTANDING.

## Structure
- mpu_state_e goes in cv32e40s_pkg.
- PMA_R_DEFAULT and pma_cfg_t come from the package.
- Instantiates cv32e40s_pma as the only sub-module; no other sub-modules.
- Counter and FSM are local to this module.

## Test plan
- IF_STAGE=1, region 0x0000_0000–0x0FFF_FFFF main; fetch at 0x100 → forwarded, bus valid same cycle, response rdata 0xDEADBEEF returned with mpu_err=0.
- Fetch to non-main 0x2000_0000 with cnt=0 → ready same cycle, no bus valid, core_resp_valid/mpu_err high exactly one cycle later, rdata=0.
- Two permitted loads outstanding, then a blocked access → both bus responses delivered first, mpu error response one cycle after the second.
- IF_STAGE=0, misaligned store to I/O → blocked. Same store aligned to a bufferable region → bus_trans_bufferable_o=1. A load there → bufferable=0.
- MAX_OUTSTANDING=2, bus never responds → third request stalls (ready=0); a response releases it.
- Assert rst_n during MPU_ERR_WAIT → state MPU_IDLE, cnt=0, no fake response emitted after release.
